fft_reorder64: RTL and testbench
================================

FFT_REORDER64 -- requirements
Module: fft_reorder64

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning FFT frame length in samples (power of two).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning bit width of each real and imaginary sample.
REQ-003 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port di_en  input  1  input sample valid, one sample per cycle; fed from the FFT64 do_en output.
REQ-006 The block SHALL have port di_re  input  WIDTH  input real part, bit-reversed frame order.
REQ-007 The block SHALL have port di_im  input  WIDTH  input imaginary part, bit-reversed frame order.
REQ-008 The block SHALL have port do_en  output  1  output sample valid.
REQ-009 The block SHALL have port do_re  output  WIDTH  output real part, natural frequency order.
REQ-010 The block SHALL have port do_im  output  WIDTH  output imaginary part, natural frequency order.
REQ-011 The block SHALL have port do_idx  output  log2(N)  natural index k of the sample on do_re/do_im.

Function
REQ-012 The block SHALL count accepted inputs with a write counter wcnt (0..N-1) that increments only on cycles with di_en=1 and wraps N-1 -> 0.
REQ-013 The block SHALL write each accepted sample to the current write bank at address bitrev(wcnt), where bitrev reverses the log2(N) bits.
REQ-014 The block SHALL use two N-entry banks (ping-pong); on the cycle the N-th sample of a frame is accepted, the write bank SHALL toggle and the just-filled bank SHALL be marked ready.
REQ-015 Gaps in di_en SHALL hold wcnt and the write bank; no sample is lost or duplicated.
REQ-016 The block SHALL have read states IDLE and READ: IDLE -> READ when a bank is ready; READ reads addresses 0..N-1 once per cycle; at address N-1, READ -> READ (next bank) if the other bank is ready, else -> IDLE.
REQ-017 do_en SHALL be high for exactly N consecutive cycles per frame, with do_idx = 0,1,...,N-1 and do_re/do_im = the sample written to that natural address.
REQ-018 Latency: the first output (do_idx=0) SHALL appear with do_en=1 on the 2nd rising edge after the edge that accepts the frame's N-th input.
REQ-019 Back-to-back frames with continuous di_en SHALL produce continuous do_en with no idle cycle between output frames.
REQ-020 While do_en=0, do_re, do_im and do_idx SHALL hold 0.
REQ-021 Because input rate is at most one sample/cycle, reader and writer SHALL never access the same bank address in the same frame; no overrun logic is needed.
REQ-022 Sample values SHALL pass bit-exact; no scaling, rounding or sign change.

Reset
REQ-023 On a clock edge with reset=0: wcnt=0, write bank=0, both ready flags cleared, read state IDLE, do_en=0, do_re=0, do_im=0, do_idx=0.
REQ-024 Reset mid-frame SHALL discard the partial input frame and any frame in readout; do_en SHALL be 0 on the edge following the reset edge, and the first frame after release SHALL start at wcnt=0.
REQ-025 Bank RAM contents SHALL NOT be reset.

Structure
REQ-026 N, LOG2N, WIDTH defaults and the bitrev function SHALL live in the shared package fft_pkg.
REQ-027 Storage SHALL be one sub-module fft_reorder_ram: simple dual-port, 2N x 2*WIDTH, one write port, one registered read port.
REQ-028 Counters, bank select, ready flags and read FSM SHALL be in fft_reorder64 itself.

Verification
REQ-029 Impulse: 64 inputs with input position 0 = (1000,0), rest 0 -> do_idx 0 = (1000,0), all other 63 outputs (0,0).
REQ-030 Bit-reversed ramp: input position p carries re=bitrev6(p), im=-bitrev6(p) -> output k carries re=k, im=-k for k=0..63, first do_en exactly 2 edges after the 64th input.
REQ-031 Back-to-back: 3 frames with continuous di_en -> 192 consecutive do_en cycles, do_idx wrapping 63 -> 0 twice, data correct per frame.
REQ-032 Gapped input: di_en toggled 1,0,1,0 over a frame (128 cycles) -> same 64 outputs as REQ-030, emitted contiguously.
REQ-033 Reset mid-operation: assert reset after 40 inputs of frame 2 while frame 1 is in readout -> do_en=0 next edge, no further outputs until a fresh full frame, which is then correct.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fft_pkg                                                          |
// | Shared FFT defaults, read-FSM state type and bit-reverse helper. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fft_pkg;

  localparam int unsigned c_N     = 64;
  localparam int unsigned c_LOG2N = 6;
  localparam int unsigned c_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

  // Reverses the low 'bits' bits of value; bits must be a constant when synthesized.
  function automatic int unsigned bitrev(input int unsigned value, input int unsigned bits);
    int unsigned r;
    r = '0;
    for (int unsigned i = 0; i < bits; i++) begin
      r[bits - 1 - i] = value[i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fft_reorder_ram                                                  |
// | Simple dual-port RAM: one write port, one registered read port.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fft_reorder_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Contents are intentionally left unreset so this maps onto block RAM.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fft_reorder64.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fft_reorder64                                                    |
// | Ping-pong reorder of bit-reversed FFT frames into natural order. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fft_reorder64
  import fft_pkg::*;
#(
  parameter int N     = c_N,
  parameter int WIDTH = c_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 di_en,
  input  logic [WIDTH-1:0]     di_re,
  input  logic [WIDTH-1:0]     di_im,
  output logic                 do_en,
  output logic [WIDTH-1:0]     do_re,
  output logic [WIDTH-1:0]     do_im,
  output logic [$clog2(N)-1:0] do_idx
);

  localparam int LOG2N = $clog2(N);

  logic [LOG2N-1:0]   r_wcnt;
  logic               r_wbank;
  logic [1:0]         r_ready;
  rd_state_t          r_state;
  logic               r_rbank;
  logic [LOG2N-1:0]   r_raddr;
  logic               r_do_en;
  logic [LOG2N-1:0]   r_do_idx;

  logic               w_last_in;
  logic               w_rd;
  logic [LOG2N:0]     w_waddr;
  logic [LOG2N:0]     w_raddr;
  logic [2*WIDTH-1:0] w_q;

  assign w_last_in = di_en && (r_wcnt == LOG2N'(N - 1));
  assign w_rd      = (r_state == ST_READ);
  assign w_waddr   = {r_wbank, LOG2N'(bitrev(32'(r_wcnt), LOG2N))};
  assign w_raddr   = {r_rbank, r_raddr};

  fft_reorder_ram #(
    .DEPTH (2 * N),
    .AW    (LOG2N + 1),
    .DW    (2 * WIDTH)
  ) u_ram (
    .clock   (clock),
    .i_we    (di_en),
    .i_waddr (w_waddr),
    .i_wdata ({di_re, di_im}),
    .i_re    (w_rd),
    .i_raddr (w_raddr),
    .o_rdata (w_q)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wcnt   <= '0;
      r_wbank  <= 1'b0;
      r_ready  <= 2'b00;
      r_state  <= ST_IDLE;
      r_rbank  <= 1'b0;
      r_raddr  <= '0;
      r_do_en  <= 1'b0;
      r_do_idx <= '0;
    end else begin
      if (di_en) begin
        r_wcnt <= r_wcnt + LOG2N'(1);
      end
      if (w_last_in) begin
        r_wbank <= ~r_wbank;
      end

      // RAM data lands together with these, one edge after the address is issued.
      r_do_en  <= w_rd;
      r_do_idx <= w_rd ? r_raddr : '0;

      case (r_state)
        ST_IDLE: begin
          if (r_ready[r_rbank]) begin
            r_state          <= ST_READ;
            r_raddr          <= '0;
            r_ready[r_rbank] <= 1'b0;
          end
        end
        ST_READ: begin
          if (r_raddr == LOG2N'(N - 1)) begin
            r_rbank <= ~r_rbank;
            r_raddr <= '0;
            if (r_ready[~r_rbank]) begin
              r_ready[~r_rbank] <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_raddr <= r_raddr + LOG2N'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Writer and reader never target the same bank flag on one edge.
      if (w_last_in) begin
        r_ready[r_wbank] <= 1'b1;
      end
    end
  end

  assign do_en  = r_do_en;
  assign do_idx = r_do_idx;
  assign do_re  = r_do_en ? w_q[2*WIDTH-1:WIDTH] : '0;
  assign do_im  = r_do_en ? w_q[WIDTH-1:0]       : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder64.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fft_reorder64                                                 |
// | Self-checking bench: random/directed frames vs. reference model. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fft_reorder64;

  localparam int N  = 64;
  localparam int W  = 16;
  localparam int LG = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          di_en = 1'b0;
  logic [W-1:0]  di_re = '0;
  logic [W-1:0]  di_im = '0;
  logic          do_en;
  logic [W-1:0]  do_re;
  logic [W-1:0]  do_im;
  logic [LG-1:0] do_idx;

  fft_reorder64 #(.N(N), .WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .di_en  (di_en),
    .di_re  (di_re),
    .di_im  (di_im),
    .do_en  (do_en),
    .do_re  (do_re),
    .do_im  (do_im),
    .do_idx (do_idx)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           due;
    logic [LG-1:0] idx;
    logic [W-1:0]  re;
    logic [W-1:0]  im;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] frm_re [N];
  logic [W-1:0] frm_im [N];
  int           pos    = 0;
  int           cyc    = 0;
  int           errors = 0;
  int           checks = 0;

  function automatic int brev6(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LG; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, sample #1 after the edge, then update the model.
  task automatic step(input logic en, input logic [W-1:0] re, input logic [W-1:0] im);
    logic [63:0] exp_v;
    di_en = en; di_re = re; di_im = im;
    @(posedge clock);
    cyc++;
    #1;
    if (!reset) begin
      exp_q.delete();
      pos = 0;
    end
    exp_v = '0;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_v = {25'd0, 1'b1, exp_q[0].idx, exp_q[0].re, exp_q[0].im};
      void'(exp_q.pop_front());
    end
    chk("out", {25'd0, do_en, do_idx, do_re, do_im}, exp_v);
    if (reset && en) begin
      frm_re[pos] = re;
      frm_im[pos] = im;
      pos++;
      if (pos == N) begin
        // Natural output k holds the sample that arrived at position bitrev(k).
        for (int k = 0; k < N; k++) begin
          exp_t e;
          e.due = cyc + 2 + k;
          e.idx = LG'(k);
          e.re  = frm_re[brev6(k)];
          e.im  = frm_im[brev6(k)];
          exp_q.push_back(e);
        end
        pos = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0);
  endtask

  task automatic drain(input string tag);
    idle(N + 4);
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_frame(input int gap_pct);
    int sent;
    sent = 0;
    while (sent < N) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        step(1'b0, W'($urandom), W'($urandom));
      end else begin
        step(1'b1, W'($urandom), W'($urandom));
        sent++;
      end
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    step(1'b0, '0, '0);
    step(1'b1, 16'h1234, 16'h5678);
    chk("rst_state", {32'd0, do_en, do_idx, do_re, do_im}, 64'd0);
    reset = 1'b1;
    idle(3);

    // Impulse
    for (int p = 0; p < N; p++) step(1'b1, (p == 0) ? 16'd1000 : 16'd0, '0);
    drain("impulse_drain");

    // Bit-reversed ramp with explicit latency checks
    for (int p = 0; p < N; p++) step(1'b1, W'(brev6(p)), W'(-brev6(p)));
    chk("lat_edge1_en", 64'(do_en), 64'd0);
    step(1'b0, '0, '0);
    chk("lat_edge2_en", 64'(do_en), 64'd0);
    step(1'b0, '0, '0);
    chk("lat_first", {40'd0, do_en, do_idx, do_re}, {40'd0, 1'b1, 6'd0, 16'd0});
    drain("ramp_drain");

    // Three back-to-back random frames
    rand_frame(0);
    rand_frame(0);
    rand_frame(0);
    drain("b2b_drain");

    // Gapped ramp: en alternates 1,0 over 128 cycles
    for (int c = 0; c < 2 * N; c++) begin
      if (c % 2 == 0) step(1'b1, W'(brev6(c / 2)), W'(-brev6(c / 2)));
      else            step(1'b0, 16'hDEAD, 16'hBEEF);
    end
    drain("gap_drain");

    // Randomly gapped frame
    rand_frame(30);
    drain("rgap_drain");

    // Reset mid-operation: frame 1 in readout, 40 inputs into frame 2
    rand_frame(0);
    for (int i = 0; i < 40; i++) step(1'b1, W'($urandom), W'($urandom));
    reset = 1'b0;
    step(1'b1, W'($urandom), W'($urandom));
    chk("rst_mid_en", 64'(do_en), 64'd0);
    reset = 1'b1;
    idle(N + 8);
    chk("rst_mid_quiet", 64'(exp_q.size()), 64'd0);
    rand_frame(0);
    drain("rst_fresh_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
